// File: rtl/lsu_ad_arb_if.sv
// Request/grant bundle between the FU/LQ/SQ/MHQ sources and the AD-slot arbiter.
// The arbiter uses the slave modport; the sources collectively use the master modport.
interface lsu_ad_arb_if;
  logic       i_flush;
  logic       i_hold;
  logic       i_fill_req;
  logic       i_sq_req;
  logic       i_lq_req;
  logic       i_fu_req;
  logic       i_fu_is_store;
  logic       i_lq_full;
  logic       i_sq_full;
  logic       o_fill_gnt;
  logic       o_sq_gnt;
  logic       o_lq_gnt;
  logic       o_fu_gnt;
  logic       o_sq_stall;
  logic       o_lq_stall;
  logic       o_fu_stall;
  logic [2:0] o_starved;
  logic [3:0] o_last_gnt;

  modport slave (
    input  i_flush, i_hold, i_fill_req, i_sq_req, i_lq_req, i_fu_req,
           i_fu_is_store, i_lq_full, i_sq_full,
    output o_fill_gnt, o_sq_gnt, o_lq_gnt, o_fu_gnt,
           o_sq_stall, o_lq_stall, o_fu_stall, o_starved, o_last_gnt
  );

  modport master (
    output i_flush, i_hold, i_fill_req, i_sq_req, i_lq_req, i_fu_req,
           i_fu_is_store, i_lq_full, i_sq_full,
    input  o_fill_gnt, o_sq_gnt, o_lq_gnt, o_fu_gnt,
           o_sq_stall, o_lq_stall, o_fu_stall, o_starved, o_last_gnt
  );
endinterface

// File: rtl/lsu_ad_arb.sv
// Arbiter for the single LSU AD pipeline slot. Grants at most one of
// {fill, sq retire, lq replay, fu op} per cycle: fill first, then any starved
// requester (sq > lq > fu), then plain fixed priority sq > lq > fu.
// Per-requester saturating counters track consecutive denied cycles.
module lsu_ad_arb #(
  parameter  int STARVE_LIMIT = 8,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input logic         clk,
  input logic         n_rst,
  lsu_ad_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // One-hot grant vector layout: {fu, lq, sq, fill}
  localparam int G_FILL = 0;
  localparam int G_SQ   = 1;
  localparam int G_LQ   = 2;
  localparam int G_FU   = 3;

  logic             fill_e, sq_e, lq_e, fu_e;
  logic             sq_sat, lq_sat, fu_sat;
  logic [3:0]       gnt;
  logic [3:0]       last_gnt_q;
  logic [CNT_W-1:0] ctr_sq_q, ctr_lq_q, ctr_fu_q;

  // Counter step: clear on grant, on request drop or on flush, else saturate upward.
  function automatic logic [CNT_W-1:0] ctr_next(input logic [CNT_W-1:0] ctr,
                                                input logic             req,
                                                input logic             won,
                                                input logic             flush);
    if (won || !req || flush) return '0;
    if (ctr == LIMIT)         return ctr;
    return ctr + 1'b1;
  endfunction

  // Eligibility: flush squashes speculative lq/fu work; fu also needs a free queue entry.
  always_comb begin
    fill_e = bus.i_fill_req;
    sq_e   = bus.i_sq_req;
    lq_e   = bus.i_lq_req & ~bus.i_flush;
    fu_e   = bus.i_fu_req & ~bus.i_flush &
             ~(bus.i_fu_is_store ? bus.i_sq_full : bus.i_lq_full);
    sq_sat = (ctr_sq_q == LIMIT);
    lq_sat = (ctr_lq_q == LIMIT);
    fu_sat = (ctr_fu_q == LIMIT);
  end

  // Priority select; grants are forced low in reset and while the AD stage holds.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves gnt unassigned (no latch).
    gnt = '0;
    if (n_rst && !bus.i_hold) begin
      if      (fill_e)          gnt[G_FILL] = 1'b1;
      else if (sq_sat && sq_e)  gnt[G_SQ]   = 1'b1;
      else if (lq_sat && lq_e)  gnt[G_LQ]   = 1'b1;
      else if (fu_sat && fu_e)  gnt[G_FU]   = 1'b1;
      else if (sq_e)            gnt[G_SQ]   = 1'b1;
      else if (lq_e)            gnt[G_LQ]   = 1'b1;
      else if (fu_e)            gnt[G_FU]   = 1'b1;
    end
  end

  // Starvation counters and previous-grant record.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ctr_sq_q   <= '0;
      ctr_lq_q   <= '0;
      ctr_fu_q   <= '0;
      last_gnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ctr_sq_q   <= ctr_next(ctr_sq_q, bus.i_sq_req, gnt[G_SQ], bus.i_flush);
      ctr_lq_q   <= ctr_next(ctr_lq_q, bus.i_lq_req, gnt[G_LQ], bus.i_flush);
      ctr_fu_q   <= ctr_next(ctr_fu_q, bus.i_fu_req, gnt[G_FU], bus.i_flush);
      last_gnt_q <= gnt;
    end
  end

  // Output drive: grants, stalls for requesters that lost, and registered status.
  always_comb begin
    bus.o_fill_gnt = gnt[G_FILL];
    bus.o_sq_gnt   = gnt[G_SQ];
    bus.o_lq_gnt   = gnt[G_LQ];
    bus.o_fu_gnt   = gnt[G_FU];
    bus.o_sq_stall = bus.i_sq_req & ~gnt[G_SQ];
    bus.o_lq_stall = bus.i_lq_req & ~gnt[G_LQ];
    bus.o_fu_stall = bus.i_fu_req & ~gnt[G_FU];
    bus.o_starved  = {fu_sat, lq_sat, sq_sat};
    bus.o_last_gnt = last_gnt_q;
  end

endmodule
